drive_sequencer: RTL and testbench

Output stage downstream of the pattern buffer: consumes its per-phase drive and tweak fields and the PWM signal, and produces the final p/n gate words for the output drivers. On every PWM edge it inserts a dead-time (all gates off), applies the base drive, waits a programmable delay, then steps through eight tweak slots. Each slot either adds lanes to or removes lanes from the active drive, after which the base drive holds until the next PWM edge.

---
 rtl/drive_sequencer_if.sv | 37 +++
 rtl/drive_sequencer.sv | 167 ++++++++++++++++
 tb/tb_drive_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/drive_sequencer_if.sv
// Bundle between the pattern buffer / PWM source and the output stage:
// per-phase drive and tweak fields in, final p/n gate words out.
interface drive_sequencer_if #(
  parameter int buffer_width = 8
);
  logic                    pwm;
  logic [buffer_width-1:0] p_drive;
  logic [buffer_width-1:0] n_drive;
  logic [buffer_width-1:0] tweak_delay;
  logic [buffer_width-1:0] tweak_sense;
  logic [buffer_width-1:0] tweak_drive_0;
  logic [buffer_width-1:0] tweak_drive_1;
  logic [buffer_width-1:0] tweak_drive_2;
  logic [buffer_width-1:0] tweak_drive_3;
  logic [buffer_width-1:0] tweak_drive_4;
  logic [buffer_width-1:0] tweak_drive_5;
  logic [buffer_width-1:0] tweak_drive_6;
  logic [buffer_width-1:0] tweak_drive_7;
  logic [buffer_width-1:0] p_gate;
  logic [buffer_width-1:0] n_gate;
  logic                    tweak_active;
  logic [2:0]              slot;

  modport master (
    output pwm, p_drive, n_drive, tweak_delay, tweak_sense,
           tweak_drive_0, tweak_drive_1, tweak_drive_2, tweak_drive_3,
           tweak_drive_4, tweak_drive_5, tweak_drive_6, tweak_drive_7,
    input  p_gate, n_gate, tweak_active, slot
  );

  modport slave (
    input  pwm, p_drive, n_drive, tweak_delay, tweak_sense,
           tweak_drive_0, tweak_drive_1, tweak_drive_2, tweak_drive_3,
           tweak_drive_4, tweak_drive_5, tweak_drive_6, tweak_drive_7,
    output p_gate, n_gate, tweak_active, slot
  );
endinterface

// File: rtl/drive_sequencer.sv
// Output stage: dead-time on every PWM edge, base drive, programmable delay,
// then eight add/remove tweak slots before holding the base drive.
//
// state    | meaning
// ST_IDLE  | gates off, waiting for the first PWM edge
// ST_DEAD  | gates off for dead_cycles after an edge
// ST_DELAY | base drive, counting down tweak_delay
// ST_TWEAK | base drive modified by tweak slot 0..7
// ST_HOLD  | base drive until the next PWM edge
module drive_sequencer #(
  parameter int buffer_width = 8,
  parameter int dead_cycles  = 2,
  parameter int slot_cycles  = 4
) (
  input  logic               clk,
  input  logic               rst,
  drive_sequencer_if.slave   bus
);

  localparam int W = buffer_width;
  localparam logic [W-1:0] DEAD_LOAD = W'(dead_cycles);
  localparam logic [W-1:0] SLOT_LOAD = W'(slot_cycles);
  localparam logic [W-1:0] ONE       = W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_DELAY,
    ST_TWEAK,
    ST_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q, cnt_d;
  logic [2:0]     slot_q, slot_d;
  logic           phase_q, phase_d;
  logic           pwm_dly_q, pwm_dly_d;
  logic [W-1:0]   p_gate_q, p_gate_d;
  logic [W-1:0]   n_gate_q, n_gate_d;
  logic           tweak_active_q, tweak_active_d;

  logic           pwm_edge;
  logic           go_delay;
  logic           go_tweak;
  logic [W-1:0]   base;
  logic [W-1:0]   mask;
  logic [W-1:0]   tweak_mask [8];

  always_comb begin
    tweak_mask[0] = bus.tweak_drive_0;
    tweak_mask[1] = bus.tweak_drive_1;
    tweak_mask[2] = bus.tweak_drive_2;
    tweak_mask[3] = bus.tweak_drive_3;
    tweak_mask[4] = bus.tweak_drive_4;
    tweak_mask[5] = bus.tweak_drive_5;
    tweak_mask[6] = bus.tweak_drive_6;
    tweak_mask[7] = bus.tweak_drive_7;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    phase_d   = phase_q;
    pwm_dly_d = bus.pwm;
    go_delay  = 1'b0;
    go_tweak  = 1'b0;
    pwm_edge  = (bus.pwm != pwm_dly_q);

    // A PWM edge restarts the sequence from any state.
    if (pwm_edge) begin
      phase_d = bus.pwm;
      slot_d  = 3'd0;
      if (dead_cycles > 0) begin
        state_d = ST_DEAD;
        cnt_d   = DEAD_LOAD;
      end else begin
        go_delay = 1'b1;
      end
    end else begin
      case (state_q)
        ST_DEAD: begin
          if (cnt_q <= ONE) go_delay = 1'b1;
          else              cnt_d    = cnt_q - ONE;
        end
        ST_DELAY: begin
          if (cnt_q <= ONE) go_tweak = 1'b1;
          else              cnt_d    = cnt_q - ONE;
        end
        ST_TWEAK: begin
          if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
          end else if (slot_q == 3'd7) begin
            state_d = ST_HOLD;
            slot_d  = 3'd0;
            cnt_d   = '0;
          end else begin
            slot_d = slot_q + 3'd1;
            cnt_d  = SLOT_LOAD;
          end
        end
        default: ;
      endcase
    end

    if (go_delay) begin
      if (bus.tweak_delay == '0) begin
        go_tweak = 1'b1;
      end else begin
        state_d = ST_DELAY;
        cnt_d   = bus.tweak_delay;
      end
    end

    if (go_tweak) begin
      state_d = ST_TWEAK;
      slot_d  = 3'd0;
      cnt_d   = SLOT_LOAD;
    end
  end

  // Gate words are built from the next state so they land on the same edge.
  always_comb begin
    base = phase_d ? ~bus.p_drive : bus.n_drive;
    mask = base;
    if (state_d == ST_TWEAK) begin
      if (bus.tweak_sense[slot_d]) mask = base | tweak_mask[slot_d];
      else                         mask = base & ~tweak_mask[slot_d];
    end

    p_gate_d       = '1;
    n_gate_d       = '0;
    tweak_active_d = (state_d == ST_TWEAK);
    if (state_d == ST_DELAY || state_d == ST_TWEAK || state_d == ST_HOLD) begin
      if (phase_d) p_gate_d = ~mask;
      else         n_gate_d = mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      slot_q         <= 3'd0;
      phase_q        <= 1'b0;
      pwm_dly_q      <= 1'b0;
      p_gate_q       <= '1;
      n_gate_q       <= '0;
      tweak_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      slot_q         <= slot_d;
      phase_q        <= phase_d;
      pwm_dly_q      <= pwm_dly_d;
      p_gate_q       <= p_gate_d;
      n_gate_q       <= n_gate_d;
      tweak_active_q <= tweak_active_d;
    end
  end

  assign bus.p_gate       = p_gate_q;
  assign bus.n_gate       = n_gate_q;
  assign bus.tweak_active = tweak_active_q;
  assign bus.slot         = slot_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer: per-cycle gate/slot expectations from a
// small timing model built on E+dead+delay+k*slot.
module tb_drive_sequencer;

  localparam int W    = 8;
  localparam int DEAD = 2;
  localparam int SLOT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drive_sequencer_if #(.buffer_width(W)) bus ();
  logic [W-1:0] tw [8];

  assign bus.tweak_drive_0 = tw[0];
  assign bus.tweak_drive_1 = tw[1];
  assign bus.tweak_drive_2 = tw[2];
  assign bus.tweak_drive_3 = tw[3];
  assign bus.tweak_drive_4 = tw[4];
  assign bus.tweak_drive_5 = tw[5];
  assign bus.tweak_drive_6 = tw[6];
  assign bus.tweak_drive_7 = tw[7];

  drive_sequencer #(
    .buffer_width (W),
    .dead_cycles  (DEAD),
    .slot_cycles  (SLOT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks    = 0;
  int n_pass      = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if ((~bus.p_gate & bus.n_gate) != '0) overlap_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after changing pwm; the first tick is the detecting edge E.
  task automatic run_seq(input bit phase, input logic [W-1:0] base, input int delay,
                         input logic [W-1:0] sense, input int ncyc, input string name);
    logic [W-1:0] m, ep, en;
    logic         ea;
    int           es, rel;
    bit           off;
    for (int t = 0; t < ncyc; t++) begin
      tick();
      off = (t < DEAD);
      ea  = 1'b0;
      es  = 0;
      m   = base;
      rel = t - DEAD - delay;
      if (!off && rel >= 0 && rel < 8 * SLOT) begin
        ea = 1'b1;
        es = rel / SLOT;
        m  = sense[es] ? (base | tw[es]) : (base & ~tw[es]);
      end
      ep = (!off && phase)  ? ~m : 8'hFF;
      en = (!off && !phase) ? m  : 8'h00;
      check($sformatf("%s p_gate E+%0d", name, t), 32'(bus.p_gate), 32'(ep));
      check($sformatf("%s n_gate E+%0d", name, t), 32'(bus.n_gate), 32'(en));
      check($sformatf("%s active E+%0d", name, t), 32'(bus.tweak_active), 32'(ea));
      check($sformatf("%s slot E+%0d", name, t), 32'(bus.slot), 32'(es));
    end
  endtask

  task automatic check_idle(input int ncyc, input string name);
    for (int t = 0; t < ncyc; t++) begin
      tick();
      check($sformatf("%s p_gate c%0d", name, t), 32'(bus.p_gate), 32'hFF);
      check($sformatf("%s n_gate c%0d", name, t), 32'(bus.n_gate), 32'h00);
      check($sformatf("%s active c%0d", name, t), 32'(bus.tweak_active), 32'h0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.pwm         = 1'b0;
    bus.p_drive     = 8'hF0;
    bus.n_drive     = 8'h00;
    bus.tweak_delay = 8'd3;
    bus.tweak_sense = 8'h00;
    for (int k = 0; k < 8; k++) tw[k] = 8'h00;

    #2;
    check("reset p_gate", 32'(bus.p_gate), 32'hFF);
    check("reset n_gate", 32'(bus.n_gate), 32'h00);
    check("reset active", 32'(bus.tweak_active), 32'h0);
    check("reset slot", 32'(bus.slot), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    check_idle(5, "idle");

    // p phase, no tweaks: base F0 from E+2, slots E+5..E+36, HOLD after
    bus.pwm = 1'b1;
    run_seq(1'b1, 8'h0F, 3, 8'h00, 40, "p_plain");

    // n phase, zero delay, slot 1 removes lane 2: 3C -> 38
    bus.n_drive     = 8'h3C;
    bus.tweak_delay = 8'd0;
    tw[1]           = 8'h04;
    bus.pwm         = 1'b0;
    run_seq(1'b0, 8'h3C, 0, 8'h00, 40, "n_rm");

    // p phase, slot 0 adds lane 4: p_gate E0 at E+5..E+8
    tw[1]           = 8'h00;
    tw[0]           = 8'h10;
    bus.tweak_sense = 8'h01;
    bus.tweak_delay = 8'd3;
    bus.pwm         = 1'b1;
    run_seq(1'b1, 8'h0F, 3, 8'h01, 40, "p_add");

    // edge during slot 3 restarts with new phase
    tw[3]           = 8'h81;
    bus.tweak_sense = 8'h09;
    bus.pwm         = 1'b0;
    run_seq(1'b0, 8'h3C, 3, 8'h09, 18, "slot3_pre");
    bus.pwm = 1'b1;
    run_seq(1'b1, 8'h0F, 3, 8'h09, 40, "restart");

    // back-to-back edges keep gates off
    for (int i = 0; i < 10; i++) begin
      bus.pwm = ~bus.pwm;
      tick();
      check($sformatf("b2b p_gate c%0d", i), 32'(bus.p_gate), 32'hFF);
      check($sformatf("b2b n_gate c%0d", i), 32'(bus.n_gate), 32'h00);
    end

    // async reset in slot 3, then idle with pwm low
    bus.pwm = 1'b0;
    run_seq(1'b0, 8'h3C, 3, 8'h09, 4, "pre_rst");
    bus.pwm = 1'b1;
    run_seq(1'b1, 8'h0F, 3, 8'h09, 18, "rst_slot3");
    #2;
    rst = 1'b1;
    #1;
    check("async rst p_gate", 32'(bus.p_gate), 32'hFF);
    check("async rst n_gate", 32'(bus.n_gate), 32'h00);
    check("async rst active", 32'(bus.tweak_active), 32'h0);
    check("async rst slot", 32'(bus.slot), 32'h0);
    bus.pwm = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_idle(6, "post_rst_idle");

    // pwm high at release counts as an edge on the first clock
    rst     = 1'b1;
    bus.pwm = 1'b1;
    tick();
    rst = 1'b0;
    run_seq(1'b1, 8'h0F, 3, 8'h09, 40, "rel_high");

    check("no p/n overlap", 32'(overlap_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
